// File: rtl/crypto_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crypto_seq_ctrl
// Description : Launches the DES or AES core, waits for its completion edge
//               with a timeout, strobes capture, and keeps sticky status/irq.
//               Optional macro CRYPTO_SEQ_LATENCY_EN enables last_latency_o.
// Revision    : 1.0 - initial release
// ============================================================================
module crypto_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_mode_i,
  input  logic             cmd_decrypt_i,
  input  logic             irq_clr_i,
  output logic             des_init_o,
  output logic             des_decrypt_o,
  input  logic             des_finish_i,
  output logic             aes_load_o,
  output logic             aes_decrypt_o,
  input  logic             aes_ready_i,
  output logic             sel_o,
  output logic             capture_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             irq_o,
  output logic [CNT_W-1:0] last_latency_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    ST_WAIT = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             prev;
  logic             cur;
  logic             edge_det;
  logic             accept;
  logic             done_set;
  logic             to_set;

  // sel_o is latched at acceptance, so it already selects the right core in LAUNCH
  assign cur      = sel_o ? aes_ready_i : des_finish_i;
  assign edge_det = cur & ~prev;
  assign accept   = (state == IDLE) & cmd_valid_i;
  assign done_set = (state == CAPTURE);
  assign to_set   = (state == ST_WAIT) & ~edge_det & (cnt == CNT_LAST);

  assign cmd_ready_o = ~busy_o;
  assign irq_o       = done_o | timeout_o;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      prev          <= 1'b0;
      sel_o         <= 1'b0;
      des_decrypt_o <= 1'b0;
      aes_decrypt_o <= 1'b0;
      des_init_o    <= 1'b0;
      aes_load_o    <= 1'b0;
      capture_o     <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      des_init_o <= 1'b0;
      aes_load_o <= 1'b0;
      capture_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            sel_o         <= cmd_mode_i;
            des_decrypt_o <= cmd_decrypt_i;
            aes_decrypt_o <= cmd_decrypt_i;
            des_init_o    <= ~cmd_mode_i;
            aes_load_o    <= cmd_mode_i;
            busy_o        <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          prev  <= cur;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          prev <= cur;
          if (edge_det) begin
            capture_o <= 1'b1;
            state     <= CAPTURE;
          end else if (cnt == CNT_LAST) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A set outranks a simultaneous clear
      if (done_set)
        done_o <= 1'b1;
      else if (irq_clr_i || accept)
        done_o <= 1'b0;

      if (to_set)
        timeout_o <= 1'b1;
      else if (irq_clr_i || accept)
        timeout_o <= 1'b0;
    end
  end

`ifdef CRYPTO_SEQ_LATENCY_EN
  logic [CNT_W-1:0] latency;

  // Edge cycle is counted, hence cnt + 1
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      latency <= '0;
    else if (state == ST_WAIT && edge_det)
      latency <= cnt + 1'b1;
  end

  assign last_latency_o = latency;
`else
  assign last_latency_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crypto_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_crypto_seq_ctrl
// Description : Directed scoreboard bench for crypto_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crypto_seq_ctrl;

  localparam int TO = 24;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_mode, cmd_dec, irq_clr;
  logic des_init, des_dec, des_finish, aes_load, aes_dec, aes_ready;
  logic sel, capture, busy, done, timeout, irq;
  logic [CW-1:0] last_latency;

  always #5 clk = ~clk;

  crypto_seq_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_mode_i(cmd_mode), .cmd_decrypt_i(cmd_dec), .irq_clr_i(irq_clr),
    .des_init_o(des_init), .des_decrypt_o(des_dec), .des_finish_i(des_finish),
    .aes_load_o(aes_load), .aes_decrypt_o(aes_dec), .aes_ready_i(aes_ready),
    .sel_o(sel), .capture_o(capture), .busy_o(busy), .done_o(done),
    .timeout_o(timeout), .irq_o(irq), .last_latency_o(last_latency)
  );

  typedef struct packed {
    logic cap;
    logic sel;
    logic dec;
    int   lat;
  } ev_t;

  ev_t  evq[$];
  logic lq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  function automatic int lexp(input int v);
`ifdef CRYPTO_SEQ_LATENCY_EN
    return v;
`else
    return (v * 0);
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a command at this negedge and queue its expected launch/outcome
  task automatic issue(input logic m, input logic d, input logic cap, input int lat,
                       input logic ends);
    ev_t e;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_dec   = d;
    lq.push_back(m);
    if (ends) begin
      e.cap = cap; e.sel = m; e.dec = d; e.lat = lat;
      evq.push_back(e);
    end
  endtask

  // Monitor: pops expectations whenever the DUT launches, captures or times out
  logic to_prev     = 1'b0;
  logic lat_pending = 1'b0;
  int   lat_exp     = 0;
  always @(negedge clk) begin
    if (rst) begin
      to_prev     = 1'b0;
      lat_pending = 1'b0;
    end else begin
      ev_t  e;
      logic m;
      if (lat_pending) begin
        chkn("latency", int'(last_latency), lexp(lat_exp));
        lat_pending = 1'b0;
      end
      if (des_init || aes_load) begin
        if (lq.size() == 0) flag("unexpected_launch");
        else begin
          m = lq.pop_front();
          chk("launch_core_aes", aes_load, m);
          chk("launch_core_des", des_init, ~m);
        end
      end
      if (capture) begin
        if (evq.size() == 0) flag("unexpected_capture");
        else begin
          e = evq.pop_front();
          chk("outcome_is_capture", 1'b1, e.cap);
          chk("capture_sel", sel, e.sel);
          chk("capture_dir", e.sel ? aes_dec : des_dec, e.dec);
          lat_exp     = e.lat;
          lat_pending = 1'b1;
        end
      end
      if (timeout && !to_prev) begin
        if (evq.size() == 0) flag("unexpected_timeout");
        else begin
          e = evq.pop_front();
          chk("outcome_is_timeout", 1'b0, e.cap);
        end
      end
      to_prev = timeout;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_dec = 1'b0; irq_clr = 1'b0;
    des_finish = 1'b0; aes_ready = 1'b0;
    cyc(3);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_capture", capture, 1'b0);
    chk("rst_des_init", des_init, 1'b0);
    chk("rst_aes_load", aes_load, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chkn("rst_latency", int'(last_latency), 0);
    rst = 1'b0;
    cyc(2);

    // DES encrypt, finish rises at N+20
    issue(1'b0, 1'b0, 1'b1, 19, 1'b1);
    cyc(1); cmd_valid = 1'b0;
    chk("t1_des_init_n1", des_init, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready_low", cmd_ready, 1'b0);
    cyc(1);
    chk("t1_des_init_n2", des_init, 1'b0);
    cyc(18);
    des_finish = 1'b1;
    cyc(1);
    chk("t1_capture_n21", capture, 1'b1);
    chk("t1_done_n21", done, 1'b0);
    cyc(1);
    chk("t1_done_n22", done, 1'b1);
    chk("t1_irq_n22", irq, 1'b1);
    chk("t1_capture_n22", capture, 1'b0);
    chk("t1_ready_n22", cmd_ready, 1'b1);
    des_finish = 1'b0;

    // AES decrypt with ready already high at launch
    aes_ready = 1'b1;
    cyc(1);
    issue(1'b1, 1'b1, 1'b1, 7, 1'b1);
    cyc(1); cmd_valid = 1'b0;
    chk("t2_aes_load", aes_load, 1'b1);
    chk("t2_done_cleared", done, 1'b0);
    chk("t2_sel", sel, 1'b1);
    chk("t2_aes_dec", aes_dec, 1'b1);
    cyc(4);
    aes_ready = 1'b0;
    chk("t2_no_early_capture", capture, 1'b0);
    chk("t2_still_busy", busy, 1'b1);
    cyc(3);
    aes_ready = 1'b1;
    cyc(1);
    chk("t2_capture", capture, 1'b1);
    chk("t2_sel_capture", sel, 1'b1);
    irq_clr = 1'b1;
    cyc(1);
    irq_clr = 1'b0;
    chk("t2_set_beats_clear", done, 1'b1);
    chk("t2_aes_dec_hold", aes_dec, 1'b1);
    cyc(2);
    irq_clr = 1'b1;
    cyc(1);
    irq_clr = 1'b0;
    chk("t2_lone_clear_done", done, 1'b0);
    chk("t2_lone_clear_irq", irq, 1'b0);

    // DES with cmd_valid held while busy and AES toggling
    issue(1'b0, 1'b0, 1'b1, 9, 1'b1);
    cyc(1);
    chk("t3_des_init", des_init, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      aes_ready = ~aes_ready;
    end
    cmd_valid = 1'b0;
    chk("t3_ignore_aes", capture, 1'b0);
    cyc(4);
    des_finish = 1'b1;
    cyc(1);
    chk("t3_capture", capture, 1'b1);
    cyc(1);
    des_finish = 1'b0;

    // Timeout: finish never rises
    issue(1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1); cmd_valid = 1'b0;
    cyc(TO);
    chk("t4_timeout_not_yet", timeout, 1'b0);
    chk("t4_busy_last_wait", busy, 1'b1);
    cyc(1);
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_irq", irq, 1'b1);
    chk("t4_ready", cmd_ready, 1'b1);
    chk("t4_done_low", done, 1'b0);
    chkn("t4_latency_hold", int'(last_latency), lexp(9));

    // Edge on the final WAIT cycle beats the timeout
    issue(1'b0, 1'b1, 1'b1, TO, 1'b1);
    cyc(1); cmd_valid = 1'b0;
    chk("t5_timeout_cleared", timeout, 1'b0);
    chk("t5_des_dec", des_dec, 1'b1);
    cyc(TO);
    des_finish = 1'b1;
    cyc(1);
    chk("t5_capture", capture, 1'b1);
    chk("t5_no_timeout", timeout, 1'b0);
    cyc(1);
    chk("t5_done", done, 1'b1);
    chk("t5_no_timeout_after", timeout, 1'b0);
    des_finish = 1'b0;

    // Reset in the middle of WAIT
    issue(1'b0, 1'b1, 1'b1, 0, 1'b0);
    cyc(1); cmd_valid = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("t6_ready", cmd_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_irq", irq, 1'b0);
    chk("t6_sel", sel, 1'b0);
    chk("t6_des_dec", des_dec, 1'b0);
    chkn("t6_latency", int'(last_latency), 0);
    des_finish = 1'b1;
    cyc(3);
    des_finish = 1'b0;
    chk("t6_no_capture", capture, 1'b0);
    cyc(3);

    chkn("launch_queue_drained", lq.size(), 0);
    chkn("event_queue_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crypto_seq_ctrl.md
Name: crypto_seq_ctrl

Overview:
- Sequencer between the Wishbone register file and the DES/AES cores; replaces manual LA-driven start/finish control.
- Accepts one command (mode, direction), launches the selected core with a 1-cycle start pulse, waits for its completion edge under a timeout, and pulses a capture strobe so the output register latches the result.
- Raises sticky done/timeout status and a level interrupt for user_irq.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort (≥2)
- CNT_W, 11, width of wait counter (must hold TIMEOUT_CYCLES)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high when a command can be accepted
- cmd_mode_i  in  1  0=DES, 1=AES
- cmd_decrypt_i  in  1  0=encrypt, 1=decrypt
- irq_clr_i  in  1  clears sticky done/timeout/irq
- des_init_o  out  1  DES start pulse
- des_decrypt_o  out  1  DES direction
- des_finish_i  in  1  DES finish level
- aes_load_o  out  1  AES start pulse
- aes_decrypt_o  out  1  AES direction
- aes_ready_i  in  1  AES ready level
- sel_o  out  1  output mux select (latched mode)
- capture_o  out  1  1-cycle strobe: latch core output
- busy_o  out  1  operation in progress
- done_o  out  1  sticky: last op completed
- timeout_o  out  1  sticky: last op timed out
- irq_o  out  1  done_o | timeout_o
- last_latency_o  out  CNT_W  see Optional Feature

Behaviour:
- Reset: state IDLE. All outputs 0 except cmd_ready_o=1. Counter=0, edge-detect history=0. Reset mid-operation aborts immediately with no capture.
- States: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE: cmd_ready_o=1. On cmd_valid_i at cycle N, latch mode/decrypt, clear done_o/timeout_o, go to LAUNCH.
- LAUNCH (N+1): des_init_o=1 if mode=0, else aes_load_o=1, for exactly one cycle. Clear counter. Go to WAIT.
- WAIT: count cycles. Completion is a rising edge (current=1, previous=0) of the selected core's finish/ready; the other core's signal is ignored. Edge history tracks the selected signal from LAUNCH onward, so a level already high at launch is not a completion.
  - Edge at cycle M: go to CAPTURE.
  - Counter == TIMEOUT_CYCLES-1 with no edge: set timeout_o, go to IDLE, no capture.
  - Edge and timeout in the same cycle: the edge wins.
- CAPTURE (M+1): capture_o=1 for one cycle. done_o=1 from M+2. Return to IDLE.
- sel_o, des_decrypt_o and aes_decrypt_o hold the latched values from acceptance until the next accepted command; they stay stable through CAPTURE.
- busy_o=1 in LAUNCH, WAIT and CAPTURE. cmd_ready_o=!busy_o. cmd_valid_i is ignored while busy.
- irq_clr_i clears done_o and timeout_o. If a set and a clear occur in the same cycle, the set wins.
- Counter saturates and never wraps.

Optional Feature:
- Macro CRYPTO_SEQ_LATENCY_EN.
- Defined: last_latency_o is updated at CAPTURE with the number of WAIT cycles spent (LAUNCH excluded; edge cycle included). It holds until the next successful op, is unchanged on timeout, and is 0 at reset.
- Undefined: last_latency_o is tied to 0 and no extra register exists.

Test Plan:
- DES encrypt: cmd_valid (mode=0, dec=0) at N -> des_init_o high only at N+1. des_finish_i rises at N+20 -> capture_o at N+21, done_o/irq_o high at N+22, last_latency_o=19 (macro on).
- AES decrypt with aes_ready_i already high at launch: no completion until ready falls and rises again -> capture only after the real rising edge; aes_decrypt_o=1 and sel_o=1 throughout.
- Timeout, TIMEOUT_CYCLES=8: finish never rises -> timeout_o=1 after 8 WAIT cycles, no capture_o, cmd_ready_o=1 next cycle.
- Busy rejection and clear: cmd_valid held during WAIT -> no second launch. irq_clr_i asserted on the same cycle done_o sets -> done_o stays 1; a later lone irq_clr_i -> 0.
- Reset mid-WAIT: wb_rst_i for 1 cycle -> all outputs 0, cmd_ready_o=1; a subsequent finish edge produces no capture.
- Wrong-core edge: mode=0 and aes_ready_i toggles -> ignored; op completes only on des_finish_i.
